// File: rtl/fpu_normalize_round.sv
// Normalize-and-round stage for single-precision results: one left shift per
// cycle, round-to-nearest-even, then classify as normal/overflow/underflow.
module fpu_normalize_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] in_M,
  input  logic [9:0]  in_E,
  input  logic        in_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] M_out,
  output logic [7:0]  E_out,
  output logic [4:0]  required_modify,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        invalid_flag
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t             state, state_nxt;
  logic [26:0]        m;
  logic signed [9:0]  e;

  // Rounding and classification datapath, consumed only in ROUND.
  logic               round_up;
  logic [24:0]        m_inc;
  logic [23:0]        m_rnd;
  logic signed [10:0] e_rnd;
  logic signed [10:0] uf_amt;
  logic [4:0]         uf_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    round_up = m[1] & (m[0] | m[2]);
    // m[26] is always clear once in ROUND, so bit 24 of the sum is the round carry.
    m_inc    = m[26:2] + 25'd1;
    m_rnd    = m[25:2];
    e_rnd    = {e[9], e};
    if (round_up) begin
      if (m_inc[24]) begin
        m_rnd = 24'h800000;
        e_rnd = {e[9], e} + 11'sd1;
      end else begin
        m_rnd = m_inc[23:0];
      end
    end
    uf_amt   = 11'sd1 - e_rnd;
    uf_shift = (uf_amt > 11'sd31) ? 5'd31 : uf_amt[4:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_invalid || (in_M == 27'd0)) state_nxt = DONE;
          else if (in_M[26] || in_M[25])     state_nxt = ROUND;
          else                               state_nxt = SHIFT;
        end
      end
      // The shift that moves a set bit from 24 into 25 is the last one.
      SHIFT:   if (m[24]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the working registers are reset along with the outputs; they are few and it keeps reset state fully defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m               <= '0;
      e               <= '0;
      M_out           <= '0;
      E_out           <= '0;
      required_modify <= '0;
      overflow_flag   <= 1'b0;
      underflow_flag  <= 1'b0;
      invalid_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_invalid || (in_M == 27'd0)) begin
              M_out           <= '0;
              E_out           <= '0;
              required_modify <= '0;
              overflow_flag   <= 1'b0;
              underflow_flag  <= 1'b0;
              invalid_flag    <= in_invalid;
            end else if (in_M[26]) begin
              m <= {1'b0, in_M[26:2], in_M[1] | in_M[0]};
              e <= in_E + 10'd1;
            end else begin
              m <= in_M;
              e <= in_E;
            end
          end
        end
        SHIFT: begin
          m <= {m[25:0], 1'b0};
          e <= e - 10'sd1;
        end
        ROUND: begin
          M_out           <= '0;
          E_out           <= '0;
          required_modify <= '0;
          overflow_flag   <= 1'b0;
          underflow_flag  <= 1'b0;
          invalid_flag    <= 1'b0;
          if (e_rnd >= 11'sd255) begin
            overflow_flag <= 1'b1;
            E_out         <= 8'hFF;
          end else if (e_rnd <= 11'sd0) begin
            underflow_flag  <= 1'b1;
            M_out           <= m_rnd[22:0];
            required_modify <= uf_shift;
          end else begin
            E_out <= e_rnd[7:0];
            M_out <= m_rnd[22:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
